point_mem_arbiter: RTL and testbench

//  Owns the 16x8 point memory used by the line-scan datapath. Shares its single port between one

---
 rtl/pm_pkg.sv | 35 +++
 rtl/pm_rr_pick.sv | 31 +++
 rtl/point_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_point_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// -----------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the point memory arbiter and its clients:
//   - arbiter FSM state encoding
//   - point memory depth and word width
//   - the 16-entry default point image that is loaded into the memory at reset.
//     The scan engines' reference model reads the same constant.
// No ports (package).
// -----------------------------------------------------------------------------
package pm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_LOCK = 2'd3
    } pm_state_t;

    localparam int PM_DEPTH  = 16;
    localparam int PM_WORD_W = 8;

    // Address 0 sits in the least significant byte.
    // addr 0..15: 01,FF,00,00, 00,02,00,00, 00,02,FF,05, 00,02,00,02
    localparam logic [PM_DEPTH*PM_WORD_W-1:0] PM_DEFAULT_IMAGE = {
        8'h02, 8'h00, 8'h02, 8'h00,
        8'h05, 8'hFF, 8'h02, 8'h00,
        8'h00, 8'h00, 8'h02, 8'h00,
        8'h00, 8'h00, 8'hFF, 8'h01
    };

    function automatic logic [PM_WORD_W-1:0] pm_default_word(input logic [3:0] addr);
        return PM_DEFAULT_IMAGE[{addr, 3'b000} +: PM_WORD_W];
    endfunction

endpackage

// File: rtl/pm_rr_pick.sv
// -----------------------------------------------------------------------------
// pm_rr_pick
// Two-way round-robin picker with starvation override.
// Ports:
//   i_req          in  2  reader requests
//   i_starved      in  2  reader has waited long enough to outrank the writer
//   i_rr_ptr       in  1  reader preferred when both candidates compete
//   o_pick         out 2  one-hot (or zero) chosen reader
//   o_starved_win  out 1  the pick comes from the starved set
// -----------------------------------------------------------------------------
module pm_rr_pick (
    input  logic [1:0] i_req,
    input  logic [1:0] i_starved,
    input  logic       i_rr_ptr,
    output logic [1:0] o_pick,
    output logic       o_starved_win
);

    logic [1:0] w_starved_req;
    logic [1:0] w_cand;

    assign w_starved_req = i_req & i_starved;
    assign o_starved_win = |w_starved_req;

    // Starved requesters form the candidate set when any exist, so a
    // non-starved reader can never jump ahead of a starved one.
    assign w_cand = o_starved_win ? w_starved_req : i_req;

    assign o_pick = (w_cand == 2'b11) ? (i_rr_ptr ? 2'b10 : 2'b01) : w_cand;

endmodule

// File: rtl/point_mem_arbiter.sv
// -----------------------------------------------------------------------------
// point_mem_arbiter
// Owns the point memory and shares its single port between one writer and
// two readers, one access per cycle. Priority outside a lock:
// starved reader > writer > round-robin reader. A reader holding rd_lock keeps
// the port for up to MAX_LOCK consecutive reads.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data writer request, held until wr_gnt
//   wr_gnt                 write performed at this edge
//   rd_req/rd_lock/rd_addr per-reader request, burst lock, addresses
//   rd_gnt                 read accepted at this edge (one-hot or zero)
//   rd_valid/rd_data       registered read result, one cycle after rd_gnt
// -----------------------------------------------------------------------------
module point_mem_arbiter
    import pm_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int STARVE_LIM = 4,
    parameter int MAX_LOCK   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_gnt,
    input  logic [1:0]          rd_req,
    input  logic [1:0]          rd_lock,
    input  logic [2*ADDR_W-1:0] rd_addr,
    output logic [1:0]          rd_gnt,
    output logic [1:0]          rd_valid,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int WAIT_W = $clog2(STARVE_LIM + 1);
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STARVE_LIM);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    pm_state_t          r_state, r_state_next;
    logic               r_rr_ptr, r_rr_ptr_next;
    logic               r_owner, r_owner_next;
    logic [LOCK_W-1:0]  r_lock_cnt, r_lock_cnt_next;
    logic [WAIT_W-1:0]  r_wait_cnt [2];
    logic [WAIT_W-1:0]  r_wait_cnt_next [2];
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [1:0]         r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;

    logic [1:0]         w_starved;
    logic [1:0]         w_pick;
    logic               w_starved_win;
    logic               w_lock_hold;
    logic               w_rr_eff;
    logic               w_rd_sel;
    logic [ADDR_W-1:0]  w_rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_reader
            assign w_starved[gi] = (r_wait_cnt[gi] >= WAIT_SAT);
            // Waiting time only accumulates across consecutive ungranted requests.
            assign r_wait_cnt_next[gi] = (rd_req[gi] && !rd_gnt[gi])
                ? ((r_wait_cnt[gi] == WAIT_SAT) ? WAIT_SAT : r_wait_cnt[gi] + WAIT_W'(1))
                : '0;
        end
    endgenerate

    // The lock continues only while the owner keeps both request and lock up
    // and its burst budget is not used up.
    assign w_lock_hold = (r_state == S_LOCK) && rd_req[r_owner] && rd_lock[r_owner]
                         && (r_lock_cnt < LOCK_MAX);

    // On the lock exit cycle the owner counts as just served.
    assign w_rr_eff = (r_state == S_LOCK) ? ~r_owner : r_rr_ptr;

    pm_rr_pick u_pick (
        .i_req         (rd_req),
        .i_starved     (w_starved),
        .i_rr_ptr      (w_rr_eff),
        .o_pick        (w_pick),
        .o_starved_win (w_starved_win)
    );

    always_comb begin
        wr_gnt          = 1'b0;
        rd_gnt          = 2'b00;
        w_rd_sel        = 1'b0;
        r_state_next    = r_state;
        r_rr_ptr_next   = r_rr_ptr;
        r_owner_next    = r_owner;
        r_lock_cnt_next = r_lock_cnt;
        if (!reset) begin
            if (w_lock_hold) begin
                w_rd_sel        = r_owner;
                rd_gnt          = r_owner ? 2'b10 : 2'b01;
                r_lock_cnt_next = r_lock_cnt + LOCK_W'(1);
                r_rr_ptr_next   = ~r_owner;
                r_state_next    = S_LOCK;
            end else begin
                if (w_starved_win) begin
                    rd_gnt = w_pick;
                end else if (wr_req) begin
                    wr_gnt = 1'b1;
                end else begin
                    rd_gnt = w_pick;
                end
                w_rd_sel = rd_gnt[1];
                if (wr_gnt) begin
                    r_state_next = S_WR;
                end else if (rd_gnt != 2'b00) begin
                    r_rr_ptr_next = ~w_rd_sel;
                    if (rd_lock[w_rd_sel]) begin
                        r_state_next    = S_LOCK;
                        r_owner_next    = w_rd_sel;
                        r_lock_cnt_next = LOCK_W'(1);
                    end else begin
                        r_state_next = S_RD;
                    end
                end else begin
                    r_state_next = S_IDLE;
                end
            end
        end
    end

    assign w_rd_addr = w_rd_sel ? rd_addr[ADDR_W +: ADDR_W] : rd_addr[0 +: ADDR_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 1'b0;
            r_owner       <= 1'b0;
            r_lock_cnt    <= '0;
            r_wait_cnt[0] <= '0;
            r_wait_cnt[1] <= '0;
            r_rd_valid    <= 2'b00;
            r_rd_data     <= '0;
        end else begin
            r_state    <= r_state_next;
            r_rr_ptr   <= r_rr_ptr_next;
            r_owner    <= r_owner_next;
            r_lock_cnt <= r_lock_cnt_next;
            r_wait_cnt <= r_wait_cnt_next;
            r_rd_valid <= rd_gnt;
            if (rd_gnt != 2'b00) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    // Reset reloads the default image; grants are forced low during reset,
    // so a write presented in that cycle never lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(pm_default_word(4'(i)));
            end
        end else if (wr_gnt) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reset suppresses a result that is already sitting in the output register.
    assign rd_valid = r_rd_valid & {2{~reset}};
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_point_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_point_mem_arbiter
// Directed scenarios followed by randomized traffic. The driver computes the
// expected grant and read result with a behavioural model and pushes them into
// queues; a separate monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_point_mem_arbiter;

    localparam int STARVE_LIM = 4;
    localparam int MAX_LOCK   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_gnt;
    logic [1:0] rd_req;
    logic [1:0] rd_lock;
    logic [7:0] rd_addr;
    logic [1:0] rd_gnt;
    logic [1:0] rd_valid;
    logic [7:0] rd_data;

    always #5 clock = ~clock;

    point_mem_arbiter #(
        .DATA_W     (8),
        .ADDR_W     (4),
        .STARVE_LIM (STARVE_LIM),
        .MAX_LOCK   (MAX_LOCK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .rd_req   (rd_req),
        .rd_lock  (rd_lock),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] exp_gnt_q [$];   // {wr_gnt, rd_gnt[1:0]} per cycle
    logic [8:0] exp_rd_q  [$];   // {reader, data} per read result

    logic [7:0] img [16] = '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
                             8'h00, 8'h02, 8'hFF, 8'h05, 8'h00, 8'h02, 8'h00, 8'h02};

    // Reference model state
    logic [7:0] m_mem [16];
    int         m_wait [2];
    bit         m_locked;
    int         m_owner;
    int         m_lock_cnt;
    int         m_rr;
    bit         pend_v;
    logic [8:0] pend;
    int         last_winner;

    task automatic model_reset();
        m_mem      = img;
        m_wait[0]  = 0;
        m_wait[1]  = 0;
        m_locked   = 0;
        m_owner    = 0;
        m_lock_cnt = 0;
        m_rr       = 0;
    endtask

    // One clock cycle: drive inputs, predict what the DUT must do at the next edge.
    task automatic cycle(input logic rst, input logic wr, input logic [3:0] wa,
                         input logic [7:0] wd, input logic [1:0] req, input logic [1:0] lk,
                         input logic [3:0] a0, input logic [3:0] a1);
        int win;
        bit cont;
        int rr;
        int best;
        int rank;
        @(negedge clock);
        #1;
        reset   = rst;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = req;
        rd_lock = lk;
        rd_addr = {a1, a0};
        // The result of last cycle's read shows now unless reset hides it.
        if (pend_v && !rst) exp_rd_q.push_back(pend);
        pend_v = 0;
        if (rst) begin
            exp_gnt_q.push_back(3'b000);
            model_reset();
            last_winner = -1;
            return;
        end
        win  = -1;
        cont = 0;
        if (m_locked && req[m_owner] && lk[m_owner] && m_lock_cnt < MAX_LOCK) begin
            win  = m_owner;
            cont = 1;
        end else begin
            // Rank candidates: starved readers 0/1, writer 2, other readers 4/5;
            // within a tier the reader favoured by round-robin ranks first.
            rr   = m_locked ? 1 - m_owner : m_rr;
            best = 100;
            for (int r = 0; r < 2; r++) begin
                if (req[r]) begin
                    rank = ((m_wait[r] >= STARVE_LIM) ? 0 : 4) + ((r == rr) ? 0 : 1);
                    if (rank < best) begin
                        best = rank;
                        win  = r;
                    end
                end
            end
            if (wr && best > 2) begin
                best = 2;
                win  = 2;
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (req[r] && win != r) m_wait[r] = (m_wait[r] + 1 > STARVE_LIM) ? STARVE_LIM : m_wait[r] + 1;
            else m_wait[r] = 0;
        end
        if (win == 2) begin
            exp_gnt_q.push_back(3'b100);
            m_mem[wa] = wd;
            m_locked  = 0;
        end else if (win >= 0) begin
            exp_gnt_q.push_back((win == 1) ? 3'b010 : 3'b001);
            pend_v = 1;
            pend   = {win[0], m_mem[(win == 1) ? a1 : a0]};
            m_rr   = 1 - win;
            if (cont) begin
                m_lock_cnt++;
            end else if (lk[win]) begin
                m_locked   = 1;
                m_owner    = win;
                m_lock_cnt = 1;
            end else begin
                m_locked = 0;
            end
        end else begin
            exp_gnt_q.push_back(3'b000);
            m_locked = 0;
        end
        last_winner = win;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 4'd0, 4'd0);
    endtask

    // Monitor: compares grants every cycle and read results whenever rd_valid is up.
    logic [2:0] mon_e;
    logic [2:0] mon_a;
    logic [8:0] mon_r;
    logic [1:0] mon_v;
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (exp_gnt_q.size() > 0) begin
                mon_e = exp_gnt_q.pop_front();
                mon_a = {wr_gnt, rd_gnt};
                n_cmp++;
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL grant @%0t: got wr=%b rd=%b, expected wr=%b rd=%b",
                             $time, mon_a[2], mon_a[1:0], mon_e[2], mon_e[1:0]);
                end
                n_cmp++;
                if ($countones(mon_a) > 1) begin
                    n_bad++;
                    $display("FAIL onehot @%0t: got wr=%b rd=%b, expected at most one grant",
                             $time, mon_a[2], mon_a[1:0]);
                end
            end
            if (rd_valid !== 2'b00) begin
                n_cmp++;
                if (exp_rd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_valid @%0t: got rd_valid=%b, expected 00", $time, rd_valid);
                end else begin
                    mon_r = exp_rd_q.pop_front();
                    mon_v = mon_r[8] ? 2'b10 : 2'b01;
                    if (rd_valid !== mon_v || rd_data !== mon_r[7:0]) begin
                        n_bad++;
                        $display("FAIL rd_data @%0t: got valid=%b data=%h, expected valid=%b data=%h",
                                 $time, rd_valid, rd_data, mon_v, mon_r[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        int g;
        logic       r_rst;
        logic       r_wr;
        logic [1:0] r_req;
        logic [1:0] r_lk;
        reset       = 1'b1;
        wr_req      = 1'b0;
        wr_addr     = 4'd0;
        wr_data     = 8'd0;
        rd_req      = 2'b00;
        rd_lock     = 2'b00;
        rd_addr     = 8'd0;
        pend_v      = 0;
        pend        = '0;
        last_winner = -1;
        model_reset();

        repeat (3) cycle(1'b1, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 4'd0, 4'd0);

        // Reader0 reads default image words 0, 1, 11.
        cycle(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 2'b00, 4'd0,  4'd0);
        cycle(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 2'b00, 4'd1,  4'd0);
        cycle(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 2'b00, 4'd11, 4'd0);
        idle();

        // Both readers, no lock: alternate.
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 4'd0, 8'd0, 2'b11, 2'b00, 4'(k), 4'(k + 6));
        idle();

        // Writer vs reader1: starvation after STARVE_LIM cycles.
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 4'd15, 8'(k + 8'h40), 2'b10, 2'b00, 4'd0, 4'd9);
        idle();

        // Reader0 locked burst on addrs 4,5 against writer and reader1.
        g = 0;
        for (int k = 0; k < 14 && g < 3; k++) begin
            cycle(1'b0, 1'b1, 4'd14, 8'h77, 2'b11, 2'b01, (g == 0) ? 4'd4 : 4'd5, 4'd7);
            if (last_winner == 0) g++;
        end
        idle();

        // Write then read-back, then reset restores the image.
        cycle(1'b0, 1'b1, 4'd3, 8'h2A, 2'b00, 2'b00, 4'd0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0, 8'd0,  2'b10, 2'b00, 4'd0, 4'd3);
        idle();
        cycle(1'b1, 1'b0, 4'd0, 8'd0,  2'b00, 2'b00, 4'd0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0, 8'd0,  2'b10, 2'b00, 4'd0, 4'd3);
        idle();

        // Reset right after a read grant, with everyone requesting.
        cycle(1'b0, 1'b0, 4'd0, 8'd0,  2'b01, 2'b00, 4'd1, 4'd0);
        cycle(1'b1, 1'b1, 4'd2, 8'h99, 2'b11, 2'b11, 4'd1, 4'd2);
        idle();
        cycle(1'b0, 1'b0, 4'd0, 8'd0,  2'b01, 2'b00, 4'd2, 4'd0);
        idle();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r_rst    = ($urandom_range(0, 199) == 0);
            r_wr     = ($urandom_range(0, 9) < 6);
            r_req[0] = ($urandom_range(0, 9) < 6);
            r_req[1] = ($urandom_range(0, 9) < 6);
            r_lk[0]  = ($urandom_range(0, 9) < 4);
            r_lk[1]  = ($urandom_range(0, 9) < 4);
            cycle(r_rst, r_wr, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  r_req, r_lk, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        repeat (3) idle();
        @(negedge clock);
        @(negedge clock);
        #5;

        n_cmp++;
        if (exp_gnt_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d grants and %0d reads still pending, expected 0 and 0",
                     exp_gnt_q.size(), exp_rd_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
